// File: rtl/fifo_arb_pkg.sv
// Shared types and default widths for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned STAT_W        = 16;

    // Burst counter needs to hold MAX_BURST itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Optional per-producer beat and stall counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    localparam int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      busy,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                      stat_clr,
    output logic [N_REQ*STAT_W-1:0]   stat_beats,
    output logic [STAT_W-1:0]         stat_stall,
`endif
    output logic [ID_W-1:0]           owner_id
);

    localparam int unsigned CNT_W = cnt_width(MAX_BURST);

    arb_state_e        state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last_owner;
    logic [CNT_W-1:0]  beat_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              transfer;
    logic [DATA_W-1:0] data_arr [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_owner),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Write path is driven straight from the registered owner so the FIFO sees no extra latency.
    always_comb begin
        req_ready    = '0;
        transfer     = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state == ST_GRANT) begin
            req_ready[owner] = !fifo_full;
            transfer         = req_valid[owner] && !fifo_full;
            fifo_wr_en       = transfer;
            if (transfer) begin
                fifo_wr_data = data_arr[owner];
            end
        end
    end

    // Grant FSM: IDLE arbitrates for one cycle, GRANT holds until burst end or owner drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= ID_W'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner      <= pick_idx;
                        last_owner <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req_valid[owner]) begin
                        state <= ST_IDLE;
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == ST_GRANT);
        owner_id = owner;
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [N_REQ];
    logic [STAT_W-1:0] stall_q;
    logic              stall_hit;

    always_comb begin
        stall_hit = (state == ST_GRANT) && req_valid[owner] && fifo_full;
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else if (stat_clr) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (transfer && (beats_q[owner] != '1)) begin
                beats_q[owner] <= beats_q[owner] + STAT_W'(1);
            end
            if (stall_hit && (stall_q != '1)) begin
                stall_q <= stall_q + STAT_W'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            stat_beats[i*STAT_W +: STAT_W] = beats_q[i];
        end
        stat_stall = stall_q;
    end
`endif

endmodule
